// File: rtl/write_back_pkg.sv
// write_back_pkg: shared types and constants for the write-back stage
package write_back_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU,
        WB_SEL_MEM,
        WB_SEL_PC
    } write_back_select_t;

    typedef struct packed {
        logic       write_enable;
        logic [4:0] addr_rd;
    } reg_file_write_params_t;

    typedef enum logic {
        WB_IDLE,
        WB_WAIT_MEM
    } wb_state_t;

    localparam logic [2:0] LOAD_FUNCT3_LB  = 3'b000;
    localparam logic [2:0] LOAD_FUNCT3_LH  = 3'b001;
    localparam logic [2:0] LOAD_FUNCT3_LW  = 3'b010;
    localparam logic [2:0] LOAD_FUNCT3_LBU = 3'b100;
    localparam logic [2:0] LOAD_FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/write_back_stage_load_data_align.sv
// load_data_align: extracts byte/half lanes from a load word and extends them
module load_data_align
    import write_back_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // unknown funct3 codes fall through to a full-word load
    always_comb begin
        lane_b = word[{offset, 3'b000} +: 8];
        lane_h = offset[1] ? word[31:16] : word[15:0];
        data   = funct3 == LOAD_FUNCT3_LB  ? {{(XLEN-8){lane_b[7]}}, lane_b} :
                 funct3 == LOAD_FUNCT3_LBU ? {{(XLEN-8){1'b0}}, lane_b} :
                 funct3 == LOAD_FUNCT3_LH  ? {{(XLEN-16){lane_h[15]}}, lane_h} :
                 funct3 == LOAD_FUNCT3_LHU ? {{(XLEN-16){1'b0}}, lane_h} : word;
    end

endmodule

// File: rtl/write_back_stage.sv
// write_back_stage: formats load data, drives the register-file write port
// and counts retired instructions, one instruction in flight at a time
module write_back_stage
    import write_back_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int RETIRE_CNT_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  reg_file_write_params_t      in_wr_params,
    input  write_back_select_t          in_sel,
    input  logic [XLEN-1:0]             in_alu_result,
    input  logic [XLEN-1:0]             in_pc_plus4,
    input  logic [2:0]                  in_load_funct3,
    input  logic                        mem_rsp_valid,
    input  logic [XLEN-1:0]             mem_rsp_data,
    output logic                        rf_we,
    output logic [4:0]                  rf_addr,
    output logic [XLEN-1:0]             rf_wdata,
    output logic                        retire_valid,
    output logic [RETIRE_CNT_WIDTH-1:0] retire_count
);

    wb_state_t              state, state_next;
    reg_file_write_params_t cap_params;
    logic [2:0]             cap_funct3;
    logic [1:0]             cap_offset;
    logic [XLEN-1:0]        load_data;
    logic                   accept, is_load, retire_alu, retire_mem;

    assign accept     = in_valid && in_ready;
    assign is_load    = in_sel == WB_SEL_MEM && in_wr_params.write_enable;
    assign retire_alu = state == WB_IDLE && accept && !is_load;
    assign retire_mem = state == WB_WAIT_MEM && mem_rsp_valid;

    load_data_align #(.XLEN(XLEN)) u_align (
        .word   (mem_rsp_data),
        .offset (cap_offset),
        .funct3 (cap_funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WB_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == WB_IDLE) state_next = accept && is_load ? WB_WAIT_MEM : WB_IDLE;
        else                  state_next = mem_rsp_valid ? WB_IDLE : WB_WAIT_MEM;
    end

    always_comb begin
        in_ready = state == WB_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_params <= '0;
            cap_funct3 <= '0;
            cap_offset <= '0;
        end else if (accept) begin
            cap_params <= in_wr_params;
            cap_funct3 <= in_load_funct3;
            cap_offset <= in_alu_result[1:0];
        end
    end

    // the counter steps on the same edge that raises retire_valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we        <= 1'b0;
            rf_addr      <= '0;
            rf_wdata     <= '0;
            retire_valid <= 1'b0;
            retire_count <= '0;
        end else begin
            rf_we        <= 1'b0;
            retire_valid <= 1'b0;
            if (retire_alu) begin
                rf_we        <= in_wr_params.write_enable && in_wr_params.addr_rd != 5'd0;
                rf_addr      <= in_wr_params.addr_rd;
                rf_wdata     <= in_sel == WB_SEL_PC ? in_pc_plus4 : in_alu_result;
                retire_valid <= 1'b1;
            end else if (retire_mem) begin
                rf_we        <= cap_params.addr_rd != 5'd0;
                rf_addr      <= cap_params.addr_rd;
                rf_wdata     <= load_data;
                retire_valid <= 1'b1;
            end
            if (retire_alu || retire_mem) retire_count <= retire_count + 1'b1;
        end
    end

endmodule

// File: doc/write_back_stage.md
Name: write_back_stage

Overview:
- Final pipeline stage of the RV32 core. Consumes the decoded write-back controls (reg-file write params plus ALU/MEM/PC select) with their operand values, and waits for the data-memory load response when needed.
- Formats load data (byte/half extraction, sign/zero extension), drives the register-file write port, and counts retired instructions.
- Holds one instruction at a time. Upstream is throttled with a valid/ready handshake.

Parameters:
XLEN, 32, datapath and register width
RETIRE_CNT_WIDTH, 64, width of retired-instruction counter

Ports:
clk  input  1  core clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_wr_params  input  reg_file_write_params_t  write_enable, addr_rd[4:0]
in_sel  input  write_back_select_t  ALU / MEM / PC
in_alu_result  input  XLEN  ALU result; also the load address
in_pc_plus4  input  XLEN  link value for JAL/JALR
in_load_funct3  input  3  load size/sign code
mem_rsp_valid  input  1  load data valid this cycle
mem_rsp_data  input  XLEN  raw aligned 32-bit word from data memory
rf_we  output  1  register-file write strobe
rf_addr  output  5  destination register
rf_wdata  output  XLEN  write data
retire_valid  output  1  one-cycle pulse per retired instruction
retire_count  output  RETIRE_CNT_WIDTH  total retired instructions

Behaviour:
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - rf_we, retire_valid, rf_addr, rf_wdata and retire_count all go to 0.
  - Any captured instruction is discarded.
- States:
  - IDLE: in_ready = 1.
  - WAIT_MEM: in_ready = 0.
- Acceptance (in_valid && in_ready) captures wr_params, sel, pc_plus4, funct3, alu_result[1:0] and alu_result.
- Non-load path (in IDLE, sel != MEM, or write_enable = 0):
  - Retires on the next cycle.
  - rf_we, rf_addr, rf_wdata and retire_valid are registered and valid for exactly one cycle.
  - State stays IDLE, so one instruction per cycle is sustained.
- Load path (in IDLE, sel == MEM and write_enable = 1):
  - Go to WAIT_MEM. No write yet.
- WAIT_MEM:
  - On mem_rsp_valid, the formatted load data is registered. The next cycle has rf_we/retire_valid high and the state returns to IDLE.
  - Minimum load latency is acceptance → write = 2 cycles when mem_rsp_valid arrives the cycle after acceptance.
  - There is no timeout; the stage waits indefinitely.
  - A new instruction may be accepted in the same cycle the load write is presented (state is already IDLE).
- mem_rsp_valid while in IDLE is ignored.
- Write data by select:
  - ALU → alu_result.
  - PC → pc_plus4.
  - MEM → formatted load data.
- Load formatting, with off = addr[1:0]:
  - LB 000: sign-extend byte[off].
  - LBU 100: zero-extend byte[off].
  - LH 001: sign-extend half[addr[1]] (addr[0] ignored).
  - LHU 101: zero-extend half[addr[1]] (addr[0] ignored).
  - LW 010: full word, offset ignored.
  - Codes 011/110/111 are treated as LW.
- x0: rd == 0 forces rf_we = 0, but retire_valid still pulses and the counter still increments.
- write_enable = 0 (stores, branches): rf_we = 0, retire_valid pulses.
- retire_count increments by 1 on each retire_valid and wraps modulo 2^RETIRE_CNT_WIDTH.
- Reset asserted during WAIT_MEM: the pending load is dropped with no write and no retire. A later mem_rsp_valid in IDLE is ignored.

Decomposition:
- write_back_pkg (existing) keeps write_back_select_t and reg_file_write_params_t.
- Add to write_back_pkg:
  - wb_state_t enum (WB_IDLE, WB_WAIT_MEM).
  - LOAD_FUNCT3_LB/LH/LW/LBU/LHU constants.
- One combinational sub-module, load_data_align: inputs word, offset and funct3; output formatted XLEN data.

Test Plan:
- Reset, then three back-to-back ALU instrs (rd 1,2,3; data 0x11,0x22,0x33) → rf_we on three consecutive cycles with matching addr/data; retire_count = 3; in_ready never drops.
- LB, addr 0x1003, mem_rsp_data 0x80FF_0000, response 3 cycles after acceptance, rd 5 → in_ready low while waiting; write x5 = 0xFFFF_FF80 one cycle after the response.
- LHU, addr 0x1002, data 0x8001_1234 → 0x0000_8001. LH, addr 0x1000, same data → 0x0000_1234.
- JAL with rd 1, pc_plus4 0x0000_0104 → rf_wdata 0x104. ALU result with rd 0 → rf_we = 0, retire_valid = 1. Store (write_enable 0, sel MEM) → no wait, retire next cycle.
- Load accepted, reset_n pulsed low while in WAIT_MEM, then mem_rsp_valid arrives → no rf_we; retire_count = 0; in_ready = 1.
- Preload retire_count to all-ones via force, then retire one instr → count wraps to 0.
